// File: rtl/led_sweep_monitor.sv
// led_sweep_monitor: decodes a bouncing one-hot LED bar into position/direction and checks sweep legality; LED_MON_STICKY_ERR_EN adds a sticky FAULT state
module led_sweep_monitor #(
  parameter int BITS = 10,
  parameter int CNT_W = 8,
  localparam int POS_W = $clog2(BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [BITS-1:0]  q_in,
  input  logic             clr,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             locked,
  output logic             bounce,
  output logic             err,
  output logic [CNT_W-1:0] sweep_cnt
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACQ = 2'd1;
  localparam logic [1:0] TRACK = 2'd2;
`ifdef LED_MON_STICKY_ERR_EN
  localparam logic [1:0] FAULT = 2'd3;
  localparam logic [1:0] ERR_IDLE = FAULT;
  localparam logic [1:0] ERR_ACQ = FAULT;
`else
  localparam logic [1:0] ERR_IDLE = IDLE;
  localparam logic [1:0] ERR_ACQ = ACQ;
  logic unused_clr;
  assign unused_clr = clr;
`endif
  logic [1:0] state, state_n;
  logic [POS_W-1:0] idx, e, pos_n;
  logic [POS_W:0] iw, pw;
  logic oh, adj, dir_n, bounce_n, err_n;
  logic [CNT_W-1:0] cnt_n;
  assign oh = (q_in != '0) && ((q_in & (q_in - BITS'(1))) == '0);
  assign iw = {1'b0, idx};
  assign pw = {1'b0, pos};
  assign adj = (iw == pw + (POS_W+1)'(1)) || (pw == iw + (POS_W+1)'(1));
  assign e = dir ? (pos == POS_W'(BITS-1) ? pos - POS_W'(1) : pos + POS_W'(1))
                 : (pos == '0 ? POS_W'(1) : pos - POS_W'(1));
  assign locked = state == TRACK;
  // index of the lit LED (meaningful only when the sample is one-hot)
  always_comb begin
    idx = '0;
    for (int i = 0; i < BITS; i++) if (q_in[i]) idx = POS_W'(i);
  end
  // next-state and output decision for one sampled step
  always_comb begin
    state_n = state;
    pos_n = pos;
    dir_n = dir;
    cnt_n = sweep_cnt;
    bounce_n = 1'b0;
    err_n = 1'b0;
`ifdef LED_MON_STICKY_ERR_EN
    if (state == FAULT) begin
      if (clr) state_n = IDLE;
    end else
`endif
    if (valid) begin
      if (!oh) begin
        err_n = 1'b1;
        state_n = ERR_IDLE;
      end else if (state == IDLE) begin
        pos_n = idx;
        state_n = ACQ;
      end else if (state == ACQ) begin
        pos_n = idx;
        state_n = adj ? TRACK : ERR_ACQ;
        err_n = !adj;
        dir_n = adj ? idx > pos : dir;
        cnt_n = adj ? '0 : sweep_cnt;
      end else begin
        pos_n = idx;
        if (idx == e) begin
          bounce_n = (idx > pos) != dir;
          dir_n = idx > pos;
          cnt_n = ((idx > pos) != dir && sweep_cnt != '1) ? sweep_cnt + CNT_W'(1) : sweep_cnt;
        end else begin
          err_n = 1'b1;
          state_n = ERR_ACQ;
        end
      end
    end
  end
  // state and output registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pos <= '0;
      dir <= 1'b0;
      sweep_cnt <= '0;
      bounce <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      pos <= pos_n;
      dir <= dir_n;
      sweep_cnt <= cnt_n;
      bounce <= bounce_n;
      err <= err_n;
    end
endmodule

// File: tb/tb_led_sweep_monitor.sv
// tb_led_sweep_monitor: directed bench with a behavioural sweep model checked every cycle plus literal spot checks
module tb_led_sweep_monitor;
  logic clk = 0, rst = 1, valid = 0, clr = 0;
  logic [9:0] q = '0;
  logic [3:0] pos, pos2;
  logic dir, locked, bounce, err, dir2, locked2, bounce2, err2;
  logic [7:0] cnt;
  logic [1:0] cnt2;
  int n_tests = 0, n_fail = 0;
  int mst, mpos, mdir, mcnt, mb, me;
`ifdef LED_MON_STICKY_ERR_EN
  localparam bit STICKY = 1;
`else
  localparam bit STICKY = 0;
`endif

  led_sweep_monitor d (.clk(clk), .rst(rst), .valid(valid), .q_in(q), .clr(clr), .pos(pos), .dir(dir),
    .locked(locked), .bounce(bounce), .err(err), .sweep_cnt(cnt));
  led_sweep_monitor #(.CNT_W(2)) d2 (.clk(clk), .rst(rst), .valid(valid), .q_in(q), .clr(clr), .pos(pos2),
    .dir(dir2), .locked(locked2), .bounce(bounce2), .err(err2), .sweep_cnt(cnt2));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] x);
    n_tests++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, a, x);
    end
  endtask

  // model: 0 idle, 1 acquiring, 2 tracking, 3 fault
  always @(posedge clk or posedge rst)
    if (rst) begin
      mst = 0; mpos = 0; mdir = 0; mcnt = 0; mb = 0; me = 0;
    end else begin
      int n, ex;
      mb = 0; me = 0;
      n = $clog2(q);
      if (mst == 3) begin
        if (clr) mst = 0;
      end else if (valid) begin
        if ($countones(q) != 1) begin
          me = 1; mst = STICKY ? 3 : 0;
        end else if (mst == 0) begin
          mpos = n; mst = 1;
        end else if (mst == 1) begin
          if (n - mpos == 1 || mpos - n == 1) begin
            mdir = n > mpos; mst = 2; mcnt = 0;
          end else begin
            me = 1; mst = STICKY ? 3 : 1;
          end
          mpos = n;
        end else begin
          if (mdir) ex = (mpos == 9) ? 8 : mpos + 1;
          else ex = (mpos == 0) ? 1 : mpos - 1;
          if (n == ex) begin
            if ((n > mpos) != (mdir == 1)) begin
              mdir = !mdir; mb = 1; mcnt++;
            end
          end else begin
            me = 1; mst = STICKY ? 3 : 1;
          end
          mpos = n;
        end
      end
    end

  always @(negedge clk)
    if (!rst) begin
      check("pos", pos, mpos);
      check("dir", dir, mdir);
      check("locked", locked, mst == 2);
      check("bounce", bounce, mb);
      check("err", err, me);
      check("cnt", cnt, mcnt > 255 ? 255 : mcnt);
      check("cnt2", cnt2, mcnt > 3 ? 3 : mcnt);
      check("pos2", pos2, mpos);
      check("locked2", locked2, mst == 2);
    end

  task automatic smp(input logic [9:0] v);
    valid = 1; q = v;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_pos", pos, 0);
    check("rst_locked", locked, 0);
    check("rst_cnt", cnt, 0);
    check("rst_err", err, 0);
    rst = 0;
`ifndef LED_MON_STICKY_ERR_EN
    smp(10'h001); check("acq_pos", pos, 0); check("acq_locked", locked, 0);
    smp(10'h002); check("lock", locked, 1); check("lock_dir", dir, 1); check("lock_pos", pos, 1);
    smp(10'h004); check("pos2", pos, 2); check("no_err", err, 0);
    for (int i = 3; i <= 9; i++) smp(10'(1 << i));
    smp(10'h100);
    check("b1", bounce, 1); check("b1_dir", dir, 0); check("b1_pos", pos, 8); check("b1_cnt", cnt, 1);
    smp(10'h080); check("b1_off", bounce, 0);
    for (int i = 6; i >= 0; i--) smp(10'(1 << i));
    smp(10'h002); check("b2", bounce, 1); check("b2_cnt", cnt, 2); check("b2_dir", dir, 1);
    smp(10'h004);
    smp(10'h010); check("jump_err", err, 1); check("jump_lock", locked, 0); check("jump_pos", pos, 4);
    smp(10'h020); check("relock", locked, 1); check("relock_dir", dir, 1); check("relock_cnt", cnt, 0);
    smp(10'h040);
    smp(10'h000); check("zero_err", err, 1); check("zero_pos", pos, 6); check("zero_lock", locked, 0);
    smp(10'h003); check("two_err", err, 1); check("two_pos", pos, 6);
    smp(10'h200); check("idle_acq", pos, 9);
    smp(10'h001); check("wrap_err", err, 1); check("wrap_pos", pos, 0); check("wrap_lock", locked, 0);
    clr = 1;
    smp(10'h002); check("wrap_relock", locked, 1);
    clr = 0;
    valid = 0; q = 10'h3ff;
    repeat (5) @(posedge clk);
    #1;
    check("hold_pos", pos, 1); check("hold_lock", locked, 1);
    for (int r = 0; r < 4; r++) begin
      for (int i = (r == 0) ? 2 : 1; i <= 9; i++) smp(10'(1 << i));
      for (int i = 8; i >= 0; i--) smp(10'(1 << i));
    end
    check("sat8", cnt, 7);
    check("sat2", cnt2, 3);
    @(negedge clk); #2 rst = 1; #1;
    check("mid_rst_pos", pos, 0); check("mid_rst_lock", locked, 0); check("mid_rst_cnt", cnt, 0);
    check("mid_rst_dir", dir, 0);
    @(negedge clk); #2 rst = 0;
`else
    smp(10'h001); smp(10'h002); check("s_lock", locked, 1);
    smp(10'h010); check("s_err", err, 1); check("s_lock0", locked, 0);
    smp(10'h020); check("s_err_once", err, 0); check("s_pos_frozen", pos, 4);
    smp(10'h040); check("s_ignored", locked, 0);
    clr = 1;
    smp(10'h080); check("s_clr_lock", locked, 0);
    clr = 0;
    smp(10'h001); check("s_acq_pos", pos, 0);
    smp(10'h002); check("s_relock", locked, 1); check("s_relock_dir", dir, 1);
`endif
    valid = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
